mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
Multiply/divide unit controller for the 5-stage MIPS core. It accepts MDU operations from the EX stage and sequences multi-cycle mult/multu/div/divu. It owns the HI/LO architectural registers and drives the decode-stage stall request for any MDU-class instruction while the unit is occupied. Arithmetic is done by one combinational sub-module; this block owns timing, the occupancy counter, commit and protocol checking.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; sampled on posedge clk
start  in  1  EX stage holds a valid MDU write-class op this cycle
op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
src_a  in  32  rs operand, already forwarded
src_b  in  32  rt operand, already forwarded
d_is_md  in  1  decode-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
hi  out  32  architectural HI
lo  out  32  architectural LO
busy  out  1  multi-cycle operation in flight (registered)
stall_req  out  1  combinational: d_is_md & (busy | start_md), where start_md = start & op in 1..4
dz_pulse  out  1  one-cycle pulse: a div/divu was accepted with src_b == 0
proto_err  out  1  one-cycle pulse: start with a nonzero op was refused

Behaviour:
- Reset values: hi=0, lo=0, busy=0, counter=0, pending result=0, dz_pulse=0, proto_err=0; state is IDLE.
- Reset mid-operation: the pending result is discarded and HI/LO are cleared. Reset has priority over all other inputs.
- States: IDLE and RUN.
- IDLE, start with op 1..4:
  - latch the 64-bit result from the md_calc sub-module;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN; busy=1 from the next cycle.
- IDLE, start with op 5/6: write src_a to hi/lo at this edge; no busy, no stall.
- IDLE, start with op 7: ignored, proto_err pulse.
- op 0, or start=0: no action.
- RUN:
  - counter decrements every cycle;
  - on the edge where counter==1, commit the pending result (hi=upper 32, lo=lower 32), clear busy, return to IDLE.
  - busy is therefore high for exactly N cycles, and the new HI/LO are visible in the cycle busy first reads 0.
- start with nonzero op while in RUN: the op is refused (no effect on hi/lo/counter) and proto_err pulses. The issuer must honour stall_req, so this is a bench-detectable protocol violation.
- mfhi/mflo are read directly from the hi/lo outputs; they are not sequenced here beyond stall_req.
- Arithmetic:
  - mult: signed 32x32 -> 64.
  - multu: unsigned 32x32 -> 64.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
- Divide by zero (div/divu, src_b==0): the operation still occupies DIV_CYCLES, then leaves hi/lo unchanged (nothing is committed). dz_pulse fires on the accept edge.
- stall_req is asserted in the same cycle an op is accepted if d_is_md is high, so the decode instruction right behind a mult stalls immediately.

Decomposition:
- Shared package mdu_pkg holds:
  - the op encodings MDU_NONE..MDU_MTLO;
  - default latency constants MDU_MULT_CYCLES=5 and MDU_DIV_CYCLES=10;
  - the state encoding IDLE/RUN.
- One sub-module, md_calc: purely combinational. Inputs op, src_a, src_b. Outputs a 64-bit {hi,lo} result and a div-by-zero flag. The sequencer instantiates it once and registers its output at accept.

Test Plan:
- Reset, then mult with src_a=0xFFFFFFFD (-3), src_b=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div with src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat as divu 7/2 -> lo=3, hi=1.
- mthi 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0. Then divu with src_b=0 -> dz_pulse one cycle, busy 10 cycles, hi/lo unchanged.
- multu 0xFFFFFFFF*0xFFFFFFFF with d_is_md=1 held -> stall_req high in the accept cycle and all 5 busy cycles, low after. Result hi=0xFFFFFFFE, lo=0x00000001.
- mult accepted, then start with op=mtlo at RUN cycle 2 -> proto_err pulse, lo unaffected until the mult commits its own result.
- div accepted, reset asserted at RUN cycle 4 -> next cycle busy=0, hi=lo=0, and no later commit occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the sequencer state encoding.
package mdu_pkg;

  // Operation codes presented by the EX stage on the op bus.
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  // Default occupancy of the unit, in cycles.
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // Sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // True for the four multi-cycle arithmetic ops.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // True for the two divide ops.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Purely combinational multiply/divide datapath. Produces the {hi,lo} pair
// for mult/multu/div/divu and flags a zero divisor for the divide ops.
module md_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] safe_mag_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] sq;
  logic [31:0] sr;

  // Signed division is done on magnitudes and the signs re-applied, so the
  // most-negative / -1 case falls out naturally as 0x80000000 rem 0; the
  // divisor is forced non-zero so no undefined divide is ever built.
  always_comb begin
    prod_s     = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u     = {32'd0, src_a} * {32'd0, src_b};
    mag_a      = src_a[31] ? (32'd0 - src_a) : src_a;
    mag_b      = src_b[31] ? (32'd0 - src_b) : src_b;
    safe_b     = (src_b == 32'd0) ? 32'd1 : src_b;
    safe_mag_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uq         = src_a / safe_b;
    ur         = src_a % safe_b;
    sq_mag     = mag_a / safe_mag_b;
    sr_mag     = mag_a % safe_mag_b;
    sq         = (src_a[31] ^ src_b[31]) ? (32'd0 - sq_mag) : sq_mag;
    sr         = src_a[31] ? (32'd0 - sr_mag) : sr_mag;
    div_zero   = is_div_op(op) && (src_b == 32'd0);
    result     = 64'd0;
    case (mdu_op_e'(op))
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = {sr, sq};
      MDU_DIVU:  result = {ur, uq};
      default:   result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit controller. Accepts ops from EX, holds the unit busy
// for a fixed latency, then commits the latched result into HI/LO.
//
// Handshake: start/op is a one-cycle request from EX with no ready return;
// the issuer must hold MDU-class decode instructions while stall_req is high.
// A non-zero op arriving while the unit is in RUN is refused and flagged
// with a one-cycle proto_err pulse.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req,
  output logic        dz_pulse,
  output logic        proto_err
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  mdu_state_e  state;
  logic [3:0]  counter;
  logic [63:0] pending;
  logic        pend_commit;
  logic [63:0] calc_result;
  logic        calc_dz;
  logic        start_md;

  md_calc u_calc (
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .result   (calc_result),
    .div_zero (calc_dz)
  );

  // Decode stalls on any MDU instruction while the unit is, or is about to be, occupied.
  assign start_md  = start && is_md_op(op);
  assign stall_req = d_is_md && (busy || start_md);

  // Sequencer: accept in IDLE, count down in RUN, commit on the last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= 4'd0;
      pending     <= 64'd0;
      pend_commit <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      busy        <= 1'b0;
      dz_pulse    <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      dz_pulse  <= 1'b0;
      proto_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (mdu_op_e'(op))
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                pending     <= calc_result;
                pend_commit <= !calc_dz;
                dz_pulse    <= calc_dz;
                counter     <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
                busy        <= 1'b1;
                state       <= RUN;
              end
              MDU_MTHI: hi        <= src_a;
              MDU_MTLO: lo        <= src_a;
              MDU_RSVD: proto_err <= 1'b1;
              default:  ;
            endcase
          end
        end
        RUN: begin
          if (start && (op != 3'd0)) begin
            proto_err <= 1'b1;
          end
          if (counter == 4'd1) begin
            // A zero-divisor op occupies the unit but leaves HI/LO untouched.
            if (pend_commit) begin
              hi <= pending[63:32];
              lo <= pending[31:0];
            end
            counter <= 4'd0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed scenarios plus a random
// run, scored against an arithmetic reference model of HI/LO.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;
  logic        dz_pulse;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  // Reference architectural state and expected-result scoreboard.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] exp_q[$];

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .d_is_md   (d_is_md),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req),
    .dz_pulse  (dz_pulse),
    .proto_err (proto_err)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference arithmetic using 64-bit integer math; returns {hi,lo}.
  function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] prev);
    int ia, ib;
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = a;  ub = b;
    res = prev;
    case (o)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (b != 0) begin
        uq = ua / ub; ur = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      default: res = prev;
    endcase
    return res;
  endfunction

  // Driver: present one op for a single edge. Called and returns at posedge+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
  endtask

  // Count cycles with busy high (bounded), tallying pulses seen along the way.
  task automatic count_busy(output int n, output int dz_n, output int pe_n, output int st_n);
    n = 0; dz_n = 0; pe_n = 0; st_n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      dz_n += int'(dz_pulse);
      pe_n += int'(proto_err);
      st_n += int'(stall_req);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    start = 0; op = 0; src_a = 0; src_b = 0; d_is_md = 1; reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_hi = 0; m_lo = 0;
    total++;
    if ({hi, lo, busy, dz_pulse, proto_err, stall_req} !== 68'd0) begin
      bad++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b dz=%b pe=%b stall=%b, want all 0",
               hi, lo, busy, dz_pulse, proto_err, stall_req);
    end
    d_is_md = 0;
  endtask

  // Run one multi-cycle op and check occupancy, dz pulse and committed HI/LO.
  task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    int n, dz_n, pe_n, st_n, want_n, want_dz;
    logic [63:0] e;
    exp_q.push_back(ref_calc(o, a, b, {m_hi, m_lo}));
    want_n  = (o >= 3'd3) ? 10 : 5;
    want_dz = ((o >= 3'd3) && (b == 0)) ? 1 : 0;
    issue(o, a, b);
    count_busy(n, dz_n, pe_n, st_n);
    e = exp_q.pop_front();
    {m_hi, m_lo} = e;
    total++;
    if (n != want_n) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, n, want_n);
    end
    total++;
    if (dz_n != want_dz) begin
      bad++;
      $display("FAIL %s_dz_pulses: got %0d want %0d", name, dz_n, want_dz);
    end
    total++;
    if ({hi, lo} !== e) begin
      bad++;
      $display("FAIL %s_result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_mult();
    run_md("mult_neg3x5", 3'd1, 32'hFFFF_FFFD, 32'd5);
  endtask

  task automatic test_div();
    run_md("div_neg7d2", 3'd3, 32'hFFFF_FFF9, 32'd2);
    run_md("divu_7d2", 3'd4, 32'd7, 32'd2);
    run_md("div_minint", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_mthi_divzero();
    issue(3'd5, 32'h1234_5678, 32'd0);
    m_hi = 32'h1234_5678;
    total++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mthi: got hi=%h busy=%b want hi=12345678 busy=0", hi, busy);
    end
    run_md("divu_by_zero", 3'd4, 32'd99, 32'd0);
  endtask

  task automatic test_stall();
    int n, dz_n, pe_n, st_n;
    d_is_md = 1;
    start = 1; op = 3'd2; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    #1;
    total++;
    if (stall_req !== 1'b1) begin
      bad++;
      $display("FAIL stall_accept_cycle: got %b want 1", stall_req);
    end
    @(posedge clk); #1;
    start = 0; op = 0;
    count_busy(n, dz_n, pe_n, st_n);
    total++;
    if (st_n != 5 || n != 5) begin
      bad++;
      $display("FAIL stall_busy_cycles: stall=%0d busy=%0d want 5 and 5", st_n, n);
    end
    total++;
    if (stall_req !== 1'b0) begin
      bad++;
      $display("FAIL stall_after: got %b want 0", stall_req);
    end
    m_hi = 32'hFFFF_FFFE; m_lo = 32'h0000_0001;
    total++;
    if (hi !== m_hi || lo !== m_lo) begin
      bad++;
      $display("FAIL multu_max: got hi=%h lo=%h want hi=fffffffe lo=00000001", hi, lo);
    end
    d_is_md = 0;
  endtask

  task automatic test_proto();
    int n, dz_n, pe_n, st_n;
    logic [31:0] old_lo;
    old_lo = m_lo;
    issue(3'd1, 32'd7, 32'd9);
    @(posedge clk); #1;
    issue(3'd6, 32'hDEAD_BEEF, 32'd0);
    total++;
    if (proto_err !== 1'b1 || lo !== old_lo) begin
      bad++;
      $display("FAIL proto_mtlo_in_run: got pe=%b lo=%h want pe=1 lo=%h", proto_err, lo, old_lo);
    end
    count_busy(n, dz_n, pe_n, st_n);
    total++;
    if (n + 2 != 5 || pe_n != 1) begin
      bad++;
      $display("FAIL proto_busy: got busy=%0d pe_pulses=%0d want busy=5 pe_pulses=1", n + 2, pe_n);
    end
    m_hi = 32'd0; m_lo = 32'd63;
    total++;
    if (hi !== m_hi || lo !== m_lo || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL proto_commit: got hi=%h lo=%h pe=%b want hi=0 lo=3f pe=0", hi, lo, proto_err);
    end
    issue(3'd7, 32'h5555_5555, 32'd1);
    total++;
    if (proto_err !== 1'b1 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      bad++;
      $display("FAIL reserved_op: got pe=%b busy=%b hi=%h lo=%h want pe=1 busy=0 unchanged",
               proto_err, busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    int leaks;
    issue(3'd3, 32'd1000, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    m_hi = 0; m_lo = 0;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    leaks = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) leaks++;
    end
    total++;
    if (leaks != 0) begin
      bad++;
      $display("FAIL reset_no_late_commit: got %0d bad cycles want 0", leaks);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(1, 7));
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 50));
        2:       a = 32'h8000_0000;
        default: a = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (o <= 3'd4) begin
        run_md("rand_md", o, a, b);
      end else if (o == 3'd7) begin
        issue(o, a, b);
        total++;
        if (proto_err !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
          bad++;
          $display("FAIL rand_reserved: got pe=%b hi=%h lo=%h want pe=1 hi=%h lo=%h",
                   proto_err, hi, lo, m_hi, m_lo);
        end
      end else begin
        issue(o, a, b);
        if (o == 3'd5) m_hi = a; else m_lo = a;
        total++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
          bad++;
          $display("FAIL rand_move: got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
                   hi, lo, busy, m_hi, m_lo);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_divzero();
    test_stall();
    test_proto();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
